// File: rtl/qos_wrr_scheduler_if.sv
// Bundle between the QoS WRR scheduler, the four class FIFOs and the downstream FIFO.
// master = scheduler side, slave = FIFO/environment side.
interface qos_wrr_scheduler_if #(
    parameter int DATA_W = 12
);
    logic [3:0]          empty;
    logic                almost_full;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          pop;
    logic                push;
    logic [DATA_W-1:0]   data_out;
    logic [1:0]          grant_id;
    logic                busy;

    modport master (
        input  empty, almost_full, data_in,
        output pop, push, data_out, grant_id, busy
    );

    modport slave (
        output empty, almost_full, data_in,
        input  pop, push, data_out, grant_id, busy
    );
endinterface

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin drain of four class FIFOs into one downstream FIFO.
// Optional macro STRICT_P0_EN gives class 0 strict priority over the WRR rotation.
module qos_wrr_scheduler #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 4,
    parameter int W0     = 4,
    parameter int W1     = 3,
    parameter int W2     = 2,
    parameter int W3     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    qos_wrr_scheduler_if.master   bus
);

`ifdef STRICT_P0_EN
    localparam bit STRICT_P0 = 1'b1;
`else
    localparam bit STRICT_P0 = 1'b0;
`endif

    typedef enum logic {IDLE, SERVE} state_t;

    localparam logic [CNT_W-1:0] WT [4] = '{CNT_W'(W0), CNT_W'(W1), CNT_W'(W2), CNT_W'(W3)};

    state_t             state_q, state_d;
    logic [1:0]         cur_q, cur_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   credit_q, credit_d;
    logic               push_q, push_d;
    logic [1:0]         grant_q, grant_d;
    logic [3:0]         elig;
    logic [3:0]         pop;
    logic [2:0]         nxt;
    logic               pop_go;
    logic               turn_end;

    // Returns {found, class} for the first eligible class at or after start (mod 4).
    function automatic logic [2:0] search(input logic [1:0] start, input logic [3:0] el);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (el[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int c = 0; c < 4; c++) elig[c] = !bus.empty[c] && (WT[c] != '0);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        nxt      = '0;
        pop_go   = 1'b0;
        turn_end = 1'b0;

        case (state_q)
            IDLE: begin
                nxt = search(rr_ptr_q + 2'd1, elig);
                if (nxt[2]) begin
                    state_d  = SERVE;
                    cur_d    = nxt[1:0];
                    credit_d = WT[nxt[1:0]];
                end
            end
            SERVE: begin
                pop_go = !bus.empty[cur_q] && !bus.almost_full &&
                         ((credit_q != '0) || (STRICT_P0 && cur_q == 2'd0));
                if (STRICT_P0 && cur_q != 2'd0 && pop_go && !bus.empty[0]) begin
                    cur_d    = 2'd0;
                    credit_d = WT[0];
                end else if (STRICT_P0 && cur_q == 2'd0) begin
                    // Strict class 0 is not credit-limited and leaves the rotation pointer alone.
                    if (bus.empty[0]) begin
                        nxt      = search(rr_ptr_q + 2'd1, elig);
                        turn_end = 1'b1;
                    end
                end else if (bus.empty[cur_q] || (pop_go && credit_q == CNT_W'(1))) begin
                    rr_ptr_d = cur_q;
                    nxt      = search(cur_q + 2'd1, elig);
                    turn_end = 1'b1;
                end else if (pop_go) begin
                    credit_d = credit_q - CNT_W'(1);
                end

                if (turn_end) begin
                    if (nxt[2]) begin
                        cur_d    = nxt[1:0];
                        credit_d = WT[nxt[1:0]];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) pop_go = 1'b0;
        pop    = pop_go ? (4'b0001 << cur_q) : 4'b0000;
        push_d = pop_go;
        if (pop_go) grant_d = cur_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rr_ptr_q <= 2'd3;
            credit_q <= '0;
            push_q   <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            push_q   <= push_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.pop      = pop;
    assign bus.push     = push_q;
    assign bus.data_out = bus.data_in[grant_q*DATA_W +: DATA_W];
    assign bus.grant_id = cur_q;
    assign bus.busy     = (state_q == SERVE);

endmodule
